// File: rtl/dma_axi_pkg.sv
// Shared AXI read-engine definitions: response/burst encodings, 4 KB page size,
// read FSM states and the burst sizing helper.
package dma_axi_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam int         AXI_4K_BYTES = 4096;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_CALC,
    RD_ADDR,
    RD_DATA,
    RD_DONE
  } rd_state_t;

  // Beats for the next burst: limited by what is left, the burst cap, and the
  // distance to the next 4 KB page. addr_lo is beat-aligned, so the page term is >= 1.
  function automatic logic [31:0] calc_burst_beats(input logic [31:0] remaining,
                                                   input logic [11:0] addr_lo,
                                                   input logic [31:0] max_burst,
                                                   input logic [31:0] bytes_log2);
    logic [31:0] to_4k;
    logic [31:0] b;
    to_4k = (32'(AXI_4K_BYTES) - {20'd0, addr_lo}) >> bytes_log2;
    b = remaining;
    if (b > max_burst) b = max_burst;
    if (b > to_4k) b = to_4k;
    return b;
  endfunction

endpackage

// File: rtl/axi_burst_read_master.sv
// DMA read engine: splits a len-beat block into INCR bursts (capped, 4 KB safe),
// one outstanding at a time, and pushes every R beat into the DMA data FIFO.
module axi_burst_read_master
  import dma_axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_wen,
  input  logic              fifo_full
);

  localparam int                BYTES_LOG2 = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((DATA_W / 8) - 1);

  rd_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  burst_cnt;
  logic [8:0]        beats;
  logic              err_sticky;
  logic              beat;
  logic              last_of_burst;
  logic              beat_err;
  logic [8:0]        calc_beats;

  assign m_axi_arsize  = 3'(BYTES_LOG2);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_rready  = (state == RD_DATA) && !fifo_full;
  assign beat          = m_axi_rvalid && m_axi_rready;
  assign fifo_wen      = beat;
  assign fifo_wdata    = m_axi_rdata;
  assign last_of_burst = (burst_cnt == LEN_W'(1));
  assign beat_err      = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_of_burst);
  assign calc_beats    = 9'(calc_burst_beats(32'(remaining), cur_addr[11:0],
                                             32'(MAX_BURST), 32'(BYTES_LOG2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RD_IDLE: if (start && (len != '0)) state_nxt = RD_CALC;
      RD_CALC: state_nxt = RD_ADDR;
      RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
      RD_DATA: if (beat && last_of_burst)
                 state_nxt = (remaining == LEN_W'(1)) ? RD_DONE : RD_CALC;
      RD_DONE: state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_sticky    <= 1'b0;
      cur_addr      <= '0;
      remaining     <= '0;
      burst_cnt     <= '0;
      beats         <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        RD_IDLE: if (start) begin
          if (len == '0) begin
            done <= 1'b1;
          end else begin
            cur_addr   <= addr & ALIGN_MASK;
            remaining  <= len;
            busy       <= 1'b1;
            err_sticky <= 1'b0;
          end
        end
        RD_CALC: begin
          beats         <= calc_beats;
          burst_cnt     <= LEN_W'(calc_beats);
          m_axi_araddr  <= cur_addr;
          m_axi_arlen   <= 8'(calc_beats - 9'd1);
          m_axi_arvalid <= 1'b1;
        end
        RD_ADDR: if (m_axi_arready) m_axi_arvalid <= 1'b0;
        RD_DATA: if (beat) begin
          burst_cnt <= burst_cnt - LEN_W'(1);
          remaining <= remaining - LEN_W'(1);
          if (beat_err) err_sticky <= 1'b1;
          if (last_of_burst) begin
            cur_addr <= cur_addr + (ADDR_W'(beats) << BYTES_LOG2);
            // Final beat of the block: fold this beat's status into the reported error.
            if (remaining == LEN_W'(1)) begin
              done <= 1'b1;
              err  <= err_sticky | beat_err;
            end
          end
        end
        RD_DONE: begin
          busy       <= 1'b0;
          err_sticky <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Bench for axi_burst_read_master: AXI read slave + FIFO stub, a queue-based model of
// the expected bursts/data/err, and a per-cycle compare process.
module tb_axi_burst_read_master;
  localparam int AW = 32, DW = 32, LW = 16, MB = 16;

  logic          clk, rst, start;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wen, fifo_full;

  axi_burst_read_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_full(fifo_full)
  );

  typedef struct { logic [31:0] a; logic [7:0] l; } ar_t;
  typedef struct { logic [31:0] a; int beats; } pend_t;

  int n_cmp = 0, n_mis = 0;
  ar_t exp_ar[$];
  ar_t ar_log[$];
  logic [31:0] exp_data[$];
  pend_t pend[$];
  logic exp_err, last_err;
  int exp_len, err_idx = -1, full_idx = -1, ar_dly = 0;
  int push_cnt, stall_cnt, done_cnt = 0, cyc = 0, start_cyc = 0, last_push_cyc = 0;
  logic slv_flush = 0, ar_hs = 0, r_hs = 0, done_prev = 0, ar_held = 0;
  logic [31:0] hs_a, held_a;
  logic [7:0]  hs_l, held_l;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'd3);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // AXI read slave and FIFO-full generator; drives at posedge+1.
  initial begin
    int beat_i, blk_beat, full_left, ar_wait;
    logic full_done;
    beat_i = 0; blk_beat = 0; full_left = 0; ar_wait = 0; full_done = 0;
    m_axi_arready = 1; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_rlast = 0; fifo_full = 0;
    forever begin
      @(posedge clk); #1;
      if (slv_flush) begin
        pend.delete(); beat_i = 0; blk_beat = 0; full_left = 0; full_done = 0; ar_wait = 0;
      end else begin
        if (r_hs && pend.size() > 0) begin
          beat_i++; blk_beat++;
          if (beat_i == pend[0].beats) begin
            void'(pend.pop_front());
            beat_i = 0;
          end
        end
        if (ar_hs) begin
          pend.push_back('{hs_a, int'(hs_l) + 1});
          ar_wait = 0;
        end else if (m_axi_arvalid) ar_wait++;
      end
      m_axi_arready = (ar_wait >= ar_dly);
      if (pend.size() > 0 && blk_beat == full_idx && !full_done) begin
        full_left = 3; full_done = 1;
      end
      fifo_full = (full_left > 0);
      if (full_left > 0) full_left--;
      m_axi_rvalid = (pend.size() > 0);
      if (m_axi_rvalid) begin
        m_axi_rdata = mem(pend[0].a + 32'(beat_i * 4));
        m_axi_rlast = (beat_i == pend[0].beats - 1);
        m_axi_rresp = (blk_beat == err_idx) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rlast = 0; m_axi_rresp = 0;
      end
    end
  end

  // Compare process: checks DUT outputs against the model every cycle at negedge.
  initial forever begin
    ar_t e;
    @(negedge clk);
    cyc++;
    ar_hs = 0; r_hs = 0;
    if (rst) begin
      done_prev = 0; ar_held = 0;
    end else begin
      if (ar_held) begin
        chk("ar_hold_valid", m_axi_arvalid, 1);
        chk("ar_hold_addr", m_axi_araddr, held_a);
        chk("ar_hold_len", m_axi_arlen, held_l);
      end
      ar_held = 0;
      if (m_axi_arvalid) begin
        chk("arsize", m_axi_arsize, 2);
        chk("arburst", m_axi_arburst, 1);
        if (m_axi_arready) begin
          ar_hs = 1; hs_a = m_axi_araddr; hs_l = m_axi_arlen;
          ar_log.push_back('{m_axi_araddr, m_axi_arlen});
          if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            e = exp_ar.pop_front();
            chk("araddr", m_axi_araddr, e.a);
            chk("arlen", m_axi_arlen, e.l);
          end
          chk("ar_4k", ({20'd0, m_axi_araddr[11:0]} + (32'(m_axi_arlen) + 1) * 4) <= 4096, 1);
        end else begin
          ar_held = 1; held_a = m_axi_araddr; held_l = m_axi_arlen;
        end
      end
      if (m_axi_rvalid) chk("rready", m_axi_rready, !fifo_full);
      chk("fifo_wen", fifo_wen, m_axi_rvalid && m_axi_rready);
      r_hs = m_axi_rvalid && m_axi_rready;
      if (m_axi_rvalid && fifo_full) stall_cnt++;
      if (fifo_wen) begin
        chk("busy_in_block", busy, 1);
        if (exp_data.size() == 0) chk("push_unexpected", 1, 0);
        else chk("fifo_wdata", fifo_wdata, exp_data.pop_front());
        push_cnt++; last_push_cyc = cyc;
      end
      if (start) start_cyc = cyc;
      if (done_prev) chk("busy_after_done", busy, 0);
      if (done) begin
        done_cnt++; last_err = err;
        chk("done_single", done_prev, 0);
        chk("done_err", err, exp_err);
        chk("done_busy", busy, exp_len != 0);
        chk("done_latency", cyc, (exp_len == 0) ? start_cyc + 1 : last_push_cyc + 1);
        chk("all_pushed", exp_data.size(), 0);
      end
      done_prev = done;
    end
  end

  // Model: expected bursts and data straight from the block rules.
  task automatic prep(input logic [31:0] a, input int n, input int e, input int f, input int d);
    logic [31:0] cur;
    int rem, b, t;
    exp_ar.delete(); exp_data.delete(); ar_log.delete();
    cur = a & ~32'h3; rem = n;
    for (int i = 0; i < n; i++) exp_data.push_back(mem(cur + 32'(i * 4)));
    while (rem > 0) begin
      b = rem;
      if (b > MB) b = MB;
      t = (4096 - int'(cur[11:0])) / 4;
      if (b > t) b = t;
      exp_ar.push_back('{cur, 8'(b - 1)});
      cur += 32'(b * 4); rem -= b;
    end
    exp_err = (e >= 0 && e < n); exp_len = n;
    err_idx = e; full_idx = f; ar_dly = d; push_cnt = 0; stall_cnt = 0;
    @(posedge clk); #2; slv_flush = 1;
    @(posedge clk); #2; slv_flush = 0;
  endtask

  task automatic go(input logic [31:0] a, input int n);
    addr = a; len = LW'(n); start = 1;
    @(posedge clk); #2; start = 0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clk);
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic run_block(input logic [31:0] a, input int n, input int e, input int f, input int d);
    int d0;
    prep(a, n, e, f, d);
    d0 = done_cnt;
    go(a, n);
    wait_done(d0);
    chk("ars_issued", exp_ar.size(), 0);
    chk("push_count", push_cnt, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; start = 0; addr = 0; len = 0;
    #1 rst = 1;
    #2;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);   chk("rst_err", err, 0);
    chk("rst_arvalid", m_axi_arvalid, 0); chk("rst_rready", m_axi_rready, 0);
    chk("rst_wen", fifo_wen, 0); chk("rst_araddr", m_axi_araddr, 0); chk("rst_arlen", m_axi_arlen, 0);
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // single burst
    run_block(32'h1000, 4, -1, -1, 0);
    chk("t1_ar_n", ar_log.size(), 1);
    chk("t1_araddr", ar_log[0].a, 32'h1000);
    chk("t1_arlen", ar_log[0].l, 3);
    chk("t1_err", last_err, 0);

    // MAX_BURST split, with slow arready
    run_block(32'h0, 40, -1, -1, 3);
    chk("t2_ar_n", ar_log.size(), 3);
    chk("t2_a0", ar_log[0].a, 32'h0);  chk("t2_l0", ar_log[0].l, 15);
    chk("t2_a1", ar_log[1].a, 32'h40); chk("t2_l1", ar_log[1].l, 15);
    chk("t2_a2", ar_log[2].a, 32'h80); chk("t2_l2", ar_log[2].l, 7);

    // 4 KB boundary split
    run_block(32'hFF8, 4, -1, -1, 0);
    chk("t3_ar_n", ar_log.size(), 2);
    chk("t3_a0", ar_log[0].a, 32'hFF8);  chk("t3_l0", ar_log[0].l, 1);
    chk("t3_a1", ar_log[1].a, 32'h1000); chk("t3_l1", ar_log[1].l, 1);
    run_block(32'hFC0, 20, -1, -1, 1);
    chk("t3b_a1", ar_log[1].a, 32'h1000); chk("t3b_l1", ar_log[1].l, 3);

    // FIFO backpressure on beat 2
    run_block(32'h300, 4, -1, 1, 0);
    chk("t4_stall_cycles", stall_cnt, 3);

    // error response on beat 1, then a clean block
    run_block(32'h400, 4, 0, -1, 0);
    chk("t5_err", last_err, 1);
    run_block(32'h500, 4, -1, -1, 0);
    chk("t5_next_err", last_err, 0);

    // unaligned address is forced to a beat boundary
    run_block(32'h1002, 2, -1, -1, 0);
    chk("t7_araddr", ar_log[0].a, 32'h1000);

    // zero-length block
    run_block(32'h600, 0, -1, -1, 0);
    chk("t6_no_ar", ar_log.size(), 0);

    // reset in the middle of DATA
    begin
      int d0;
      prep(32'h800, 20, -1, -1, 0);
      d0 = done_cnt;
      go(32'h800, 20);
      for (int k = 0; k < 200 && push_cnt < 5; k++) @(posedge clk);
      chk("t6_reached_data", push_cnt >= 5, 1);
      @(negedge clk); #1 rst = 1;
      #1;
      chk("mid_rst_busy", busy, 0);   chk("mid_rst_done", done, 0); chk("mid_rst_err", err, 0);
      chk("mid_rst_arvalid", m_axi_arvalid, 0); chk("mid_rst_rready", m_axi_rready, 0);
      chk("mid_rst_wen", fifo_wen, 0); chk("mid_rst_araddr", m_axi_araddr, 0);
      chk("mid_rst_arlen", m_axi_arlen, 0);
      chk("mid_rst_no_done", done_cnt, d0);
      exp_ar.delete(); exp_data.delete();
      slv_flush = 1;
      repeat (2) @(posedge clk);
      #2 slv_flush = 0; rst = 0;
    end
    run_block(32'h2000, 3, -1, -1, 0);
    chk("after_rst_ar", ar_log[0].a, 32'h2000);
    chk("after_rst_err", last_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
